// File: rtl/conv_fetch_if.sv
// conv_fetch_if: groups the conv_fetch_ctrl signals into one bundle.
//   master : the fetch controller. It receives start/cfg and the read data,
//            and it drives the read requests, the kernel, the window and the
//            position flags.
//   slave  : the environment, made up of the start source, the weight/fmap
//            memory and the MAC array.
// LEN_IN is the number of bits in one weight or fmap element.
interface conv_fetch_if #(parameter int LEN_IN = 8);
   logic                   in_start_conv;
   logic [2:0]             in_cfg_ci;
   logic [2:0]             in_cfg_co;
   logic [8*LEN_IN-1:0]    in_wdata;
   logic [8*LEN_IN-1:0]    in_fdata;
   logic                   out_readw_ctl;
   logic                   out_readi_ctl;
   logic [16*LEN_IN-1:0]   out_wreg;
   logic [24*LEN_IN-1:0]   out_win;
   logic                   out_win_valid;
   logic                   out_win_single;
   logic                   out_first_chnl;
   logic                   out_last_chnl;
   logic [5:0]             out_row;
   logic [4:0]             out_knl;
   logic                   out_end_fetch;

   modport master (
      input  in_start_conv, in_cfg_ci, in_cfg_co, in_wdata, in_fdata,
      output out_readw_ctl, out_readi_ctl, out_wreg, out_win, out_win_valid,
             out_win_single, out_first_chnl, out_last_chnl, out_row, out_knl,
             out_end_fetch
   );

   modport slave (
      output in_start_conv, in_cfg_ci, in_cfg_co, in_wdata, in_fdata,
      input  out_readw_ctl, out_readi_ctl, out_wreg, out_win, out_win_valid,
             out_win_single, out_first_chnl, out_last_chnl, out_row, out_knl,
             out_end_fetch
   );
endinterface

// File: rtl/conv_fetch_ctrl.sv
// conv_fetch_ctrl: the input-side sequencer of the CONV core.
// It walks the loops kernel -> channel -> output row -> column pair. Each
// output row takes one slot of CYC_ROW cycles:
//   cyc 0,1       : read weights (two halves of 8 elements each)
//   cyc 0..PAIRS-1: read fmap column pairs
//   the remaining cycles drain.
// Read data arrives one cycle after its request and is captured at the end of
// that next cycle. The 4x4 kernel and a 4-row x 6-column sliding window are
// kept here, together with flags that tell the MAC array which output
// positions the window can compute.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : conv_fetch_if.master (start/cfg, read bus, kernel, window, flags)
module conv_fetch_ctrl #(
   parameter int LEN_IN   = 8,
   parameter int ROWS_OUT = 61,
   parameter int PAIRS    = 32,
   parameter int CYC_ROW  = 34
) (
   input  logic          clk,
   input  logic          rst,
   conv_fetch_if.master  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] CYC_LAST = 6'(CYC_ROW - 1);
   localparam logic [5:0] ROW_LAST = 6'(ROWS_OUT - 1);
   localparam logic [5:0] NPAIR    = 6'(PAIRS);

   state_t                 state_q;
   logic [5:0]             cyc_q, row_q, row_d;
   logic [4:0]             chnl_q, chnl_d, knl_q, knl_d;
   logic [4:0]             last_chnl_q, last_knl_q;
   logic                   first_q, lastc_q, end_q;
   logic [16*LEN_IN-1:0]   wreg_q;
   logic [24*LEN_IN-1:0]   win_q;
   logic                   run, slot_end, final_slot;

   // Count 8*(n+1) is stored as its last index, {n,3'b111}. Codes above 3
   // saturate to 3.
   function automatic logic [4:0] cfg_last(input logic [2:0] c);
      return {(c > 3'd3) ? 2'd3 : c[1:0], 3'b111};
   endfunction

   assign run        = (state_q == RUN);
   assign slot_end   = run && (cyc_q == CYC_LAST);
   assign final_slot = (row_q == ROW_LAST) && (chnl_q == last_chnl_q) &&
                       (knl_q == last_knl_q);

   // These are decoded from state, so the asynchronous reset drops them at once.
   assign bus.out_readw_ctl  = run && (cyc_q < 6'd2);
   assign bus.out_readi_ctl  = run && (cyc_q < NPAIR);
   assign bus.out_win_valid  = run && (cyc_q >= 6'd3);
   assign bus.out_win_single = run && (cyc_q == 6'd3);

   assign bus.out_wreg       = wreg_q;
   assign bus.out_win        = win_q;
   assign bus.out_first_chnl = first_q;
   assign bus.out_last_chnl  = lastc_q;
   assign bus.out_row        = row_q;
   assign bus.out_knl        = knl_q;
   assign bus.out_end_fetch  = end_q;

   // Loop nest advance that applies at the end of a slot.
   always_comb begin
      row_d  = row_q + 6'd1;
      chnl_d = chnl_q;
      knl_d  = knl_q;
      if (row_q == ROW_LAST) begin
         row_d = '0;
         if (chnl_q == last_chnl_q) begin
            chnl_d = '0;
            knl_d  = knl_q + 5'd1;
         end else begin
            chnl_d = chnl_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cyc_q       <= '0;
         row_q       <= '0;
         chnl_q      <= '0;
         knl_q       <= '0;
         last_chnl_q <= '0;
         last_knl_q  <= '0;
         first_q     <= 1'b0;
         lastc_q     <= 1'b0;
         end_q       <= 1'b0;
      end else begin
         end_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.in_start_conv) begin
               state_q     <= RUN;
               last_chnl_q <= cfg_last(bus.in_cfg_ci);
               last_knl_q  <= cfg_last(bus.in_cfg_co);
               cyc_q       <= '0;
               row_q       <= '0;
               chnl_q      <= '0;
               knl_q       <= '0;
               first_q     <= 1'b1;
               lastc_q     <= 1'b0;    // there are always at least 8 channels
            end
            RUN: begin
               if (slot_end) begin
                  cyc_q <= '0;
                  if (final_slot) begin
                     state_q <= DONE;
                     end_q   <= 1'b1;
                     row_q   <= '0;
                     chnl_q  <= '0;
                     knl_q   <= '0;
                     first_q <= 1'b0;
                     lastc_q <= 1'b0;
                  end else begin
                     row_q   <= row_d;
                     chnl_q  <= chnl_d;
                     knl_q   <= knl_d;
                     first_q <= (chnl_d == 5'd0);
                     lastc_q <= (chnl_d == last_chnl_q);
                  end
               end else begin
                  cyc_q <= cyc_q + 6'd1;
               end
            end
            // A start held high keeps the block parked here. A new run needs
            // the start to go low and then high again.
            DONE: if (!bus.in_start_conv) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Capture data one cycle after its request. The window is never cleared
   // between rows: stale columns are simply not flagged valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wreg_q <= '0;
         win_q  <= '0;
      end else if (run) begin
         if (cyc_q == 6'd1) wreg_q[0        +: 8*LEN_IN] <= bus.in_wdata;
         if (cyc_q == 6'd2) wreg_q[8*LEN_IN +: 8*LEN_IN] <= bus.in_wdata;
         if ((cyc_q >= 6'd1) && (cyc_q <= NPAIR))
            win_q <= {bus.in_fdata, win_q[24*LEN_IN-1:8*LEN_IN]};
      end
   end

endmodule

// File: tb/tb_conv_fetch_ctrl.sv
// tb_conv_fetch_ctrl: scoreboard bench for conv_fetch_ctrl, built with
// ROWS_OUT=6 so that whole runs stay short.
// Stimulus tasks push the expected window records and the timed probe records
// into queues. A monitor running on the falling edge pops and compares them
// whenever the DUT shows a valid window or the probe's cycle comes up.
// A memory model answers read requests with a latency of 1. It serves:
//   fmap (row,col) = {row[1:0], col[5:0]}
//   weight element k of slot s = k + 16*s
module tb_conv_fetch_ctrl;
   localparam int LEN = 8;
   localparam int R   = 6;
   localparam int CR  = 34;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_fetch_if #(.LEN_IN(LEN)) fif();
   conv_fetch_ctrl #(.LEN_IN(LEN), .ROWS_OUT(R)) dut (.clk(clk), .rst(rst), .bus(fif));

   typedef struct { int idx; bit sgl, fst, lst; int row, knl;
                    logic [127:0] wreg; logic [191:0] win, msk; } sb_t;
   typedef struct { int idx; bit rdw, rdi, vld, sgl, fst, lst, endf, z; int row, knl; } pr_t;

   sb_t sbq[$];
   pr_t pq[$];
   int  cc = 0, base = 0, checks = 0, failures = 0;
   bit  sb_en = 0, fin_req = 0, fin_done = 0;

   function automatic logic [7:0] fv(input int row, input int col);
      return 8'((row % 4) * 64 + (col % 64));
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cc = cc + 1;
   end

   // Memory model: it samples the requests at the clock edge and drives the
   // answer for the following cycle.
   initial begin : mem
      int  wb, wh, fb, fp, r;
      bit  rw, ri, rs;
      wb = 0; wh = 0; fb = 0; fp = 0;
      fif.in_wdata = '0;
      fif.in_fdata = '0;
      forever begin
         @(posedge clk);
         rw = fif.out_readw_ctl; ri = fif.out_readi_ctl; rs = rst;
         #1;
         if (rs || rst) begin
            wb = 0; wh = 0; fb = 0; fp = 0;
            fif.in_wdata = {8{8'hEE}};
            fif.in_fdata = {8{8'hEE}};
         end else begin
            if (rw) begin
               for (int b = 0; b < 8; b++) fif.in_wdata[b*8 +: 8] = 8'(8*wh + b + 16*wb);
               wh++;
            end else begin
               if (wh != 0) wb++;
               wh = 0;
               fif.in_wdata = {8{8'hEE}};
            end
            if (ri) begin
               r = fb % R;
               for (int q = 0; q < 4; q++) begin
                  fif.in_fdata[q*8 +: 8]     = fv(r + q, 2*fp);
                  fif.in_fdata[(4+q)*8 +: 8] = fv(r + q, 2*fp + 1);
               end
               fp++;
            end else begin
               if (fp != 0) fb++;
               fp = 0;
               fif.in_fdata = {8{8'hEE}};
            end
         end
      end
   end

   // Monitor: the only process that compares.
   initial forever begin : mon
      int  rel;
      sb_t s;
      pr_t p;
      @(negedge clk);
      rel = cc - base;
      if (sb_en && fif.out_readw_ctl) chk("rdw_slot_cyc", longint'((rel % CR) < 2), 1);
      if (sb_en && fif.out_readi_ctl) chk("rdi_slot_cyc", longint'((rel % CR) < 32), 1);
      if (sb_en && fif.out_win_valid) begin
         if (sbq.size() == 0) chk("sb_extra_valid", longint'(rel), -1);
         else begin
            s = sbq.pop_front();
            chk("sb_idx", longint'(rel), longint'(s.idx));
            chk("sb_single", longint'(fif.out_win_single), longint'(s.sgl));
            chk("sb_row", longint'(fif.out_row), longint'(s.row));
            chk("sb_knl", longint'(fif.out_knl), longint'(s.knl));
            chk("sb_first", longint'(fif.out_first_chnl), longint'(s.fst));
            chk("sb_last", longint'(fif.out_last_chnl), longint'(s.lst));
            chkw("sb_wreg", {64'd0, fif.out_wreg}, {64'd0, s.wreg});
            chkw("sb_win", fif.out_win & s.msk, s.win);
         end
      end
      while (pq.size() > 0 && pq[0].idx < rel) begin
         chk("probe_missed", longint'(rel), longint'(pq[0].idx));
         void'(pq.pop_front());
      end
      if (pq.size() > 0 && pq[0].idx == rel) begin
         p = pq.pop_front();
         chk("p_readw", longint'(fif.out_readw_ctl), longint'(p.rdw));
         chk("p_readi", longint'(fif.out_readi_ctl), longint'(p.rdi));
         chk("p_valid", longint'(fif.out_win_valid), longint'(p.vld));
         chk("p_single", longint'(fif.out_win_single), longint'(p.sgl));
         chk("p_first", longint'(fif.out_first_chnl), longint'(p.fst));
         chk("p_last", longint'(fif.out_last_chnl), longint'(p.lst));
         chk("p_end", longint'(fif.out_end_fetch), longint'(p.endf));
         chk("p_row", longint'(fif.out_row), longint'(p.row));
         chk("p_knl", longint'(fif.out_knl), longint'(p.knl));
         if (p.z) begin
            chkw("p_wreg_zero", {64'd0, fif.out_wreg}, 192'd0);
            chkw("p_win_zero", fif.out_win, 192'd0);
         end
      end
      if (fin_req && !fin_done) begin
         chk("probe_left", longint'(pq.size()), 0);
         chk("sb_left", longint'(sbq.size()), 0);
         fin_done = 1;
      end
   end

   task automatic pp(input int idx, input bit rdw, rdi, vld, sgl, fst, lst, endf,
                     input int row, knl, input bit z);
      pr_t p;
      p.idx = idx; p.rdw = rdw; p.rdi = rdi; p.vld = vld; p.sgl = sgl;
      p.fst = fst; p.lst = lst; p.endf = endf; p.row = row; p.knl = knl; p.z = z;
      pq.push_back(p);
   endtask

   // Closed-form window and kernel contents for each valid cycle of a full run.
   task automatic push_full(input int nc, input int nk);
      sb_t s;
      int  r, fc;
      for (int sl = 0; sl < R*nc*nk; sl++) begin
         r = sl % R;
         for (int t = 3; t < CR; t++) begin
            s.idx = sl*CR + t; s.sgl = (t == 3); s.row = r;
            s.knl = sl / (R*nc); s.fst = ((sl / R) % nc) == 0;
            s.lst = ((sl / R) % nc) == nc - 1;
            for (int e = 0; e < 16; e++) s.wreg[e*8 +: 8] = 8'(e + 16*sl);
            s.win = '0; s.msk = '0;
            for (int m = 0; m < 6; m++) begin
               fc = 2*t - 8 + m;
               for (int q = 0; q < 4; q++)
                  if (fc >= 0) begin
                     s.win[(m*4+q)*8 +: 8] = fv(r + q, fc);
                     s.msk[(m*4+q)*8 +: 8] = 8'hFF;
                  end
            end
            sbq.push_back(s);
         end
      end
   endtask

   task automatic wait_idx(input int k);
      while ((cc - base) < k) @(negedge clk);
   endtask

   task automatic set_base();
      @(negedge clk);
      base = cc + 1;
      #1;
   endtask

   task automatic start_run(input logic [2:0] ci, input logic [2:0] co);
      @(negedge clk);
      fif.in_cfg_ci = ci; fif.in_cfg_co = co; fif.in_start_conv = 1'b1;
      base = cc + 1;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; fif.in_start_conv = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : stim
      int e;
      rst = 1'b1;
      fif.in_start_conv = 1'b0; fif.in_cfg_ci = 3'd0; fif.in_cfg_co = 3'd0;
      // Reset state, first with reset held and then after it is released.
      set_base();
      pp(1, 0,0,0,0,0,0,0, 0,0, 1);
      pp(3, 0,0,0,0,0,0,0, 0,0, 1);
      wait_idx(4);
      rst = 1'b0;
      pp(6, 0,0,0,0,0,0,0, 0,0, 1);
      wait_idx(7);

      // Full run with 8 channels and 8 kernels. Start stays high afterwards.
      start_run(3'd0, 3'd0);
      push_full(8, 8);
      sb_en = 1;
      e = R*8*8*CR;
      pp(0,     1,1,0,0,1,0,0, 0,0, 0);
      pp(e-1,   0,0,1,0,0,1,0, R-1,7, 0);
      pp(e,     0,0,0,0,0,0,1, 0,0, 0);
      pp(e+1,   0,0,0,0,0,0,0, 0,0, 0);
      pp(e+40,  0,0,0,0,0,0,0, 0,0, 0);
      wait_idx(e+41);
      sb_en = 0;

      // Drop start, then start again with cfg 3/3, which gives 32 channels.
      @(negedge clk); fif.in_start_conv = 1'b0;
      @(negedge clk);
      start_run(3'd3, 3'd3);
      pp(30*R*CR+5, 0,1,1,0,0,0,0, 0,0, 0);
      pp(31*R*CR+5, 0,1,1,0,0,1,0, 0,0, 0);
      pp(32*R*CR+5, 0,1,1,0,1,0,0, 0,1, 0);
      wait_idx(32*R*CR+6);
      do_reset();

      // Reset in the middle of a run (row 5, cyc 17), then a fresh start.
      start_run(3'd0, 3'd0);
      pp(5*CR+16, 0,1,1,0,1,0,0, 5,0, 0);
      pp(5*CR+17, 0,0,0,0,0,0,0, 0,0, 1);
      wait_idx(5*CR+16);
      @(posedge clk); #2;
      rst = 1'b1; fif.in_start_conv = 1'b0;
      wait_idx(5*CR+19);
      rst = 1'b0;
      start_run(3'd0, 3'd0);
      pp(0,  1,1,0,0,1,0,0, 0,0, 0);
      pp(3,  0,1,1,1,1,0,0, 0,0, 0);
      pp(33, 0,0,1,0,1,0,0, 0,0, 0);
      wait_idx(40);
      do_reset();

      // Counter wraps with 16 channels: chnl 0..15 under kernel 0, then kernel 1.
      start_run(3'd1, 3'd0);
      for (int c = 0; c <= 16; c++) begin
         pp(c*R*CR,        1,1,0,0, (c%16)==0, (c%16)==15, 0, 0,   c/16, 0);
         pp(c*R*CR+10,     0,1,1,0, (c%16)==0, (c%16)==15, 0, 0,   c/16, 0);
         pp((c*R+5)*CR+10, 0,1,1,0, (c%16)==0, (c%16)==15, 0, R-1, c/16, 0);
         pp((c*R+5)*CR+33, 0,0,1,0, (c%16)==0, (c%16)==15, 0, R-1, c/16, 0);
      end
      wait_idx(17*R*CR+1);
      do_reset();

      // Out-of-range cfg 7/5 must behave as 32 channels.
      start_run(3'd7, 3'd5);
      pp(30*R*CR+5,       0,1,1,0,0,0,0, 0,0, 0);
      pp(31*R*CR+5,       0,1,1,0,0,1,0, 0,0, 0);
      pp((31*R+5)*CR+33,  0,0,1,0,0,1,0, R-1,0, 0);
      pp(32*R*CR,         1,1,0,0,1,0,0, 0,1, 0);
      wait_idx(32*R*CR+1);
      do_reset();

      fin_req = 1;
      repeat (10) begin
         if (!fin_done) @(negedge clk);
      end
      if (!fin_done) $display("FAIL fin_timeout: got 0 expected 1");
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
